fifo_wr_arbiter: RTL and testbench

Round-robin write-port arbiter placed in front of the FIFO write side (write clock domain). It shares one FIFO write port between NUM_REQ requesters using valid/ready handshakes. A grant is held for a burst of up to BURST_LEN beats or until the requester signals its last beat. Writes are driven registered, never overflow the FIFO, and any FIFO write errors are counted.

---
 rtl/fifo_wr_arbiter.sv | 144 ++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NUM_REQ requesters.
// A grant covers up to BURST_LEN accepted beats, or ends early on a last beat
// or when the granted requester drops valid. The write enable and data are
// registered. Acceptance is throttled so the FIFO can never be overfilled.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no grant held; pick the next valid requester after last_grant
// BUSY  | grant held; beats accepted whenever the FIFO is not stalled
module fifo_wr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int WIDTH     = 8,
    parameter int BURST_LEN = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic [NUM_REQ-1:0]       req_valid_i,
    input  logic [NUM_REQ*WIDTH-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]       req_last_i,
    output logic [NUM_REQ-1:0]       req_ready_o,
    output logic [NUM_REQ-1:0]       grant_o,
    output logic                     busy_o,
    output logic                     wr_en_o,
    output logic [WIDTH-1:0]         wdata_o,
    input  logic                     full_i,
    input  logic                     afull_i,
    input  logic                     wr_error_i,
    output logic [7:0]               err_cnt_o
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(BURST_LEN + 1);

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(BURST_LEN);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] beat_cnt;
    logic [IDX_W-1:0] last_grant;
    logic [IDX_W-1:0] grant_idx;

    logic             stall;
    logic             cur_valid;
    logic             cur_last;
    logic [WIDTH-1:0] cur_data;
    logic             accepted;
    logic [CNT_W-1:0] beat_cnt_nxt;
    logic             burst_done;
    logic             release_grant;

    logic             arb_found;
    logic [IDX_W-1:0] arb_idx;
    logic [IDX_W-1:0] arb_cand;

    // The registered write already in flight takes the single free slot
    // when afull is high, so that case must stall as well.
    assign stall = full_i | (wr_en_o & afull_i);

    assign cur_valid = req_valid_i[grant_idx];
    assign cur_last  = req_last_i[grant_idx];
    assign cur_data  = req_data_i[grant_idx*WIDTH +: WIDTH];

    assign req_ready_o = (busy_o && !stall) ? grant_o : '0;

    assign accepted      = busy_o & ~stall & cur_valid;
    assign beat_cnt_nxt  = beat_cnt + CNT_W'(1);
    assign burst_done    = (beat_cnt_nxt == BURST_MAX);
    assign release_grant = (accepted & (cur_last | burst_done)) | ~cur_valid;

    // Round-robin search starting one past the previous grant, with wrap.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        arb_cand  = last_grant;
        for (int i = 0; i < NUM_REQ; i++) begin
            arb_cand = (arb_cand == LAST_IDX) ? '0 : arb_cand + IDX_W'(1);
            if (!arb_found && req_valid_i[arb_cand]) begin
                arb_found = 1'b1;
                arb_idx   = arb_cand;
            end
        end
    end

    // Grant FSM: arbitration in IDLE, burst tracking and release in BUSY.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state      <= IDLE;
            busy_o     <= 1'b0;
            grant_o    <= '0;
            grant_idx  <= '0;
            beat_cnt   <= '0;
            last_grant <= LAST_IDX;
        end else begin
            case (state)
                IDLE: begin
                    if (arb_found) begin
                        state     <= BUSY;
                        busy_o    <= 1'b1;
                        grant_o   <= NUM_REQ'(1) << arb_idx;
                        grant_idx <= arb_idx;
                        beat_cnt  <= '0;
                    end
                end
                BUSY: begin
                    if (release_grant) begin
                        state      <= IDLE;
                        busy_o     <= 1'b0;
                        grant_o    <= '0;
                        beat_cnt   <= '0;
                        last_grant <= grant_idx;
                    end else if (accepted) begin
                        beat_cnt <= beat_cnt_nxt;
                    end
                end
            endcase
        end
    end

    // Registered FIFO write: one cycle after the beat is accepted.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_en_o <= 1'b0;
            wdata_o <= '0;
        end else begin
            wr_en_o <= accepted;
            wdata_o <= accepted ? cur_data : '0;
        end
    end

    // Saturating count of FIFO write-error cycles; nonzero means a bug.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            err_cnt_o <= '0;
        end else if (wr_error_i && (err_cnt_o != 8'hFF)) begin
            err_cnt_o <= err_cnt_o + 8'd1;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: a per-cycle vector table for the
// last-beat, burst-split and stall cases, then hand-written sequences for
// reset, round-robin fairness, FIFO backpressure, error saturation and a
// reset in the middle of a burst.
module tb_fifo_wr_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 8;
    localparam int BL   = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst_n;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ*W-1:0]   req_data;
    logic [NREQ-1:0]     req_last;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ-1:0]     grant;
    logic                busy;
    logic                wr_en;
    logic [W-1:0]        wdata;
    logic                full_sig;
    logic                afull_sig;
    logic                wr_err_sig;
    logic [7:0]          err_cnt;

    logic full_drv, afull_drv, err_drv, fifo_en;
    int   fifo_cnt;

    fifo_wr_arbiter #(.NUM_REQ(NREQ), .WIDTH(W), .BURST_LEN(BL)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .req_valid_i (req_valid),
        .req_data_i  (req_data),
        .req_last_i  (req_last),
        .req_ready_o (req_ready),
        .grant_o     (grant),
        .busy_o      (busy),
        .wr_en_o     (wr_en),
        .wdata_o     (wdata),
        .full_i      (full_sig),
        .afull_i     (afull_sig),
        .wr_error_i  (wr_err_sig),
        .err_cnt_o   (err_cnt)
    );

    // 16-deep FIFO occupancy model (no reads) used by the backpressure test.
    always @(posedge clk) begin
        if (!fifo_en)
            fifo_cnt <= 0;
        else if (wr_en && fifo_cnt < 16)
            fifo_cnt <= fifo_cnt + 1;
    end

    assign full_sig   = fifo_en ? (fifo_cnt == 16) : full_drv;
    assign afull_sig  = fifo_en ? (fifo_cnt == 15) : afull_drv;
    assign wr_err_sig = fifo_en ? (wr_en && fifo_cnt == 16) : err_drv;

    typedef struct {
        logic [3:0]  valid;
        logic [3:0]  last;
        logic [31:0] data;
        logic        full;
        logic        afull;
        logic [3:0]  exp_grant;
        logic        exp_busy;
        logic [3:0]  exp_ready;
        logic        exp_wr;
        logic [7:0]  exp_wdata;
    } vec_t;

    vec_t vecs [16];

    int n_tests = 0;
    int n_fail  = 0;

    int         bcnt [4];
    int         n_wr, n_acc, ng, ready_bad, wr_full;
    logic       saw_full;
    logic [3:0] acc;
    logic [3:0] prev_g;
    logic [3:0] glist [8];
    logic [3:0] rr_exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        full_drv  = 1'b0;
        afull_drv = 1'b0;
        err_drv   = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // valid  last     data          full  afull  grant    busy  ready    wr    wdata
        vecs[0]  = '{4'b1010, 4'b0000, 32'h3000_A000, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00};
        vecs[1]  = '{4'b1010, 4'b0000, 32'h3000_A000, 1'b0, 1'b0, 4'b0010, 1'b1, 4'b0010, 1'b0, 8'h00};
        vecs[2]  = '{4'b1010, 4'b0010, 32'h3000_A100, 1'b0, 1'b0, 4'b0010, 1'b1, 4'b0010, 1'b1, 8'hA0};
        vecs[3]  = '{4'b1000, 4'b1000, 32'h3000_0000, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1, 8'hA1};
        vecs[4]  = '{4'b1000, 4'b1000, 32'h3000_0000, 1'b0, 1'b0, 4'b1000, 1'b1, 4'b1000, 1'b0, 8'h00};
        vecs[5]  = '{4'b0100, 4'b0000, 32'h0010_0000, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1, 8'h30};
        vecs[6]  = '{4'b0100, 4'b0000, 32'h0010_0000, 1'b0, 1'b0, 4'b0100, 1'b1, 4'b0100, 1'b0, 8'h00};
        vecs[7]  = '{4'b0100, 4'b0000, 32'h0011_0000, 1'b0, 1'b0, 4'b0100, 1'b1, 4'b0100, 1'b1, 8'h10};
        vecs[8]  = '{4'b0100, 4'b0000, 32'h0012_0000, 1'b0, 1'b1, 4'b0100, 1'b1, 4'b0000, 1'b1, 8'h11};
        vecs[9]  = '{4'b0100, 4'b0000, 32'h0012_0000, 1'b0, 1'b1, 4'b0100, 1'b1, 4'b0100, 1'b0, 8'h00};
        vecs[10] = '{4'b0100, 4'b0000, 32'h0013_0000, 1'b0, 1'b0, 4'b0100, 1'b1, 4'b0100, 1'b1, 8'h12};
        vecs[11] = '{4'b0100, 4'b0000, 32'h0014_0000, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1, 8'h13};
        vecs[12] = '{4'b0100, 4'b0000, 32'h0014_0000, 1'b0, 1'b0, 4'b0100, 1'b1, 4'b0100, 1'b0, 8'h00};
        vecs[13] = '{4'b0100, 4'b0000, 32'h0015_0000, 1'b0, 1'b0, 4'b0100, 1'b1, 4'b0100, 1'b1, 8'h14};
        vecs[14] = '{4'b0000, 4'b0000, 32'h0000_0000, 1'b0, 1'b0, 4'b0100, 1'b1, 4'b0100, 1'b1, 8'h15};
        vecs[15] = '{4'b0000, 4'b0000, 32'h0000_0000, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00};

        fifo_en   = 1'b0;
        rst_n     = 1'b0;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        full_drv  = 1'b0;
        afull_drv = 1'b0;
        err_drv   = 1'b0;

        // Reset and idle
        @(negedge clk);
        #1;
        check("rst grant", grant, 0);
        check("rst wr_en", wr_en, 0);
        check("rst busy", busy, 0);
        check("rst err_cnt", err_cnt, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("idle grant", grant, 0);
        check("idle ready", req_ready, 0);
        check("idle wr_en", wr_en, 0);
        check("idle wdata", wdata, 0);
        check("idle busy", busy, 0);
        check("idle err_cnt", err_cnt, 0);

        // Vector table: last-beat release, rotation to 3, burst split, afull stall
        do_reset();
        for (int i = 0; i < 16; i++) begin
            req_valid = vecs[i].valid;
            req_last  = vecs[i].last;
            req_data  = vecs[i].data;
            full_drv  = vecs[i].full;
            afull_drv = vecs[i].afull;
            #1;
            check($sformatf("vec%0d grant", i), grant, vecs[i].exp_grant);
            check($sformatf("vec%0d busy", i), busy, vecs[i].exp_busy);
            check($sformatf("vec%0d ready", i), req_ready, vecs[i].exp_ready);
            check($sformatf("vec%0d wr_en", i), wr_en, vecs[i].exp_wr);
            check($sformatf("vec%0d wdata", i), wdata, vecs[i].exp_wdata);
            @(negedge clk);
        end

        // Round-robin with all requesters continuously valid
        do_reset();
        for (int r = 0; r < 4; r++) bcnt[r] = 0;
        for (int k = 0; k < 8; k++) glist[k] = '0;
        ng = 0;
        n_wr = 0;
        prev_g = '0;
        req_valid = 4'hF;
        req_last  = 4'h0;
        for (int cyc = 0; cyc < 22; cyc++) begin
            for (int r = 0; r < 4; r++) req_data[r*8 +: 8] = {4'(r), 4'(bcnt[r])};
            #1;
            if (grant != 4'b0000 && grant != prev_g && ng < 8) begin
                glist[ng] = grant;
                ng++;
            end
            prev_g = grant;
            if (wr_en) begin
                check($sformatf("rr wdata%0d", n_wr), {24'h0, wdata},
                      {24'h0, 4'(n_wr / 4), 4'(n_wr % 4)});
                n_wr++;
            end
            acc = req_valid & req_ready;
            @(posedge clk);
            for (int r = 0; r < 4; r++) if (acc[r]) bcnt[r]++;
            @(negedge clk);
        end
        check("rr write count", n_wr, 16);
        check("rr grant count", ng, 5);
        for (int k = 0; k < 5; k++) check($sformatf("rr grant%0d", k), glist[k], rr_exp[k]);

        // Backpressure from a 16-deep FIFO that is never read
        do_reset();
        fifo_en = 1'b1;
        bcnt[0] = 0;
        n_wr = 0;
        n_acc = 0;
        saw_full = 1'b0;
        ready_bad = 0;
        wr_full = 0;
        for (int cyc = 0; cyc < 70; cyc++) begin
            req_valid = (bcnt[0] < 20) ? 4'b0001 : 4'b0000;
            req_data  = {24'h0, 8'(bcnt[0])};
            #1;
            if (wr_en) begin
                check($sformatf("bp wdata%0d", n_wr), {24'h0, wdata}, n_wr);
                n_wr++;
                if (full_sig) wr_full++;
            end
            if (full_sig) saw_full = 1'b1;
            if (saw_full && req_ready != 4'b0000) ready_bad++;
            acc = req_valid & req_ready;
            if (acc[0]) n_acc++;
            @(posedge clk);
            if (acc[0]) bcnt[0]++;
            @(negedge clk);
        end
        check("bp write count", n_wr, 16);
        check("bp accept count", n_acc, 16);
        check("bp full seen", saw_full, 1);
        check("bp ready after full", ready_bad, 0);
        check("bp write while full", wr_full, 0);
        check("bp fifo level", fifo_cnt, 16);
        check("bp err_cnt", err_cnt, 0);
        fifo_en = 1'b0;
        req_valid = '0;

        // Error counter saturation
        do_reset();
        err_drv = 1'b1;
        repeat (10) @(negedge clk);
        #1 check("err cnt 10", err_cnt, 10);
        repeat (245) @(negedge clk);
        #1 check("err cnt 255", err_cnt, 255);
        repeat (45) @(negedge clk);
        #1 check("err cnt sat", err_cnt, 255);
        err_drv = 1'b0;

        // Reset in the middle of requester 1's burst
        @(negedge clk);
        req_valid = 4'b0001;
        req_last  = 4'b0001;
        req_data  = 32'h0000_0055;
        @(negedge clk);
        @(negedge clk);
        req_valid = 4'b0011;
        req_last  = 4'b0000;
        req_data  = 32'h0000_6655;
        @(negedge clk);
        #1 check("mid grant1", grant, 4'b0010);
        @(negedge clk);
        #1 check("mid wr_en pre-rst", wr_en, 1);
        #1 rst_n = 1'b0;
        #1;
        check("mid rst wr_en", wr_en, 0);
        check("mid rst grant", grant, 0);
        check("mid rst busy", busy, 0);
        check("mid rst ready", req_ready, 0);
        check("mid rst err_cnt", err_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1 check("post rst grant0", grant, 4'b0001);
        req_valid = '0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
